// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Outputs depend only on the current state; in FETCH, irwrite and pcwrite also follow mem_ready.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwrite_beq,
  output logic       pcwrite_bne,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state
);

  // state    | meaning
  // FETCH    | read instruction, PC <= PC + 4 when memory is ready
  // DECODE   | register read, branch target into ALUOut, dispatch on opcode
  // MEMADR   | effective address for lw/sw
  // MEMRD    | data memory read, waits on mem_ready
  // MEMWB    | load writeback from MDR into rt
  // MEMWR    | data memory write, waits on mem_ready
  // RTYPE_EX | funct-decoded ALU operation
  // RTYPE_WB | ALU result into rd
  // BEQ_EX   | compare, PC <= ALUOut if zero
  // BNE_EX   | compare, PC <= ALUOut if not zero
  // ADDI_EX  | rs + sign-extended immediate
  // ADDI_WB  | ALU result into rt
  // JUMP_EX  | PC <= jump target
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_BNE_EX   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP_EX  = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_BNE:       state_d = S_BNE_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      // Unused encodings and all single-cycle tail states return to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwrite_beq = 1'b0;
    pcwrite_bne = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsrc       = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPE_WB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQ_EX: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcsrc       = 2'b01;
        pcwrite_beq = 1'b1;
      end
      S_BNE_EX: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcsrc       = 2'b01;
        pcwrite_bne = 1'b1;
      end
      S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDI_WB:  regwrite = 1'b1;
      S_JUMP_EX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model expands each opcode
// into its expected state path; a monitor compares every cycle against the queued expectation.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwrite_beq;
    logic       pcwrite_bne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       ctl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwrite_beq, pcwrite_bne, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwrite_beq(pcwrite_beq), .pcwrite_bne(pcwrite_bne),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .state(state)
  );

  always #5 clk = ~clk;

  // Expected control word for each state, straight from the per-state output lists.
  function automatic ctl_t exp_out(input int st, input logic mr);
    ctl_t o;
    o = '0;
    case (st)
      0:  begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
      1:  o.alusrcb = 2'b11;
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  begin o.memread = 1; o.iord = 1; end
      4:  begin o.regwrite = 1; o.memtoreg = 1; end
      5:  begin o.memwrite = 1; o.iord = 1; end
      6:  begin o.alusrca = 1; o.aluop = 2'b10; end
      7:  begin o.regwrite = 1; o.regdst = 1; end
      8:  begin o.alusrca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcwrite_beq = 1; end
      9:  begin o.alusrca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcwrite_bne = 1; end
      10: begin o.alusrca = 1; o.alusrcb = 2'b10; end
      11: o.regwrite = 1;
      12: begin o.pcwrite = 1; o.pcsrc = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  // Called just after a rising edge: drive this cycle's inputs and queue what the DUT should show.
  task automatic step(input int st, input logic mr, input logic [5:0] op, input logic rst);
    exp_t e;
    reset     = rst;
    mem_ready = mr;
    opcode    = op;
    e.st      = st[3:0];
    e.ctl     = exp_out(st, mr);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: expand an opcode and wait counts into the visited state path.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int rst_at);
    int   path[$];
    logic mrs[$];
    logic [5:0] drv_op;
    for (int i = 0; i < fw; i++) begin path.push_back(0); mrs.push_back(1'b0); end
    path.push_back(0); mrs.push_back(1'b1);
    path.push_back(1); mrs.push_back(1'($urandom_range(0, 1)));
    case (op)
      6'b100011: begin
        path.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin path.push_back(3); mrs.push_back(1'b0); end
        path.push_back(3); mrs.push_back(1'b1);
        path.push_back(4); mrs.push_back(1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        path.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin path.push_back(5); mrs.push_back(1'b0); end
        path.push_back(5); mrs.push_back(1'b1);
      end
      6'b000000: begin
        path.push_back(6); mrs.push_back(1'($urandom_range(0, 1)));
        path.push_back(7); mrs.push_back(1'($urandom_range(0, 1)));
      end
      6'b000100: begin path.push_back(8); mrs.push_back(1'($urandom_range(0, 1))); end
      6'b000101: begin path.push_back(9); mrs.push_back(1'($urandom_range(0, 1))); end
      6'b001000: begin
        path.push_back(10); mrs.push_back(1'($urandom_range(0, 1)));
        path.push_back(11); mrs.push_back(1'($urandom_range(0, 1)));
      end
      6'b000010: begin path.push_back(12); mrs.push_back(1'($urandom_range(0, 1))); end
      default: ;
    endcase
    for (int i = 0; i < path.size(); i++) begin
      // The opcode only matters in DECODE and MEMADR; scramble it everywhere else.
      drv_op = (path[i] == 1 || path[i] == 2) ? op : 6'($urandom_range(0, 63));
      step(path[i], mrs[i], drv_op, i == rst_at);
      if (i == rst_at) break;
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    ctl_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = '{pcwrite, pcwrite_beq, pcwrite_bne, iord, memread, memwrite, irwrite,
                memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc};
        vectors++;
        if (state !== e.st) begin
          miscompares++;
          $display("FAIL state: got %0d expected %0d at %0t", state, e.st, $time);
        end
        vectors++;
        if (got !== e.ctl) begin
          miscompares++;
          $display("FAIL outputs in state %0d: got %h expected %h at %0t", e.st, got, e.ctl, $time);
        end
        vectors++;
        if ((memread && memwrite) || (regwrite && (pcwrite || pcwrite_beq || pcwrite_bne))) begin
          miscompares++;
          $display("FAIL exclusive strobes: memrd=%b memwr=%b regwr=%b pcw=%b%b%b expected no overlap",
                   memread, memwrite, regwrite, pcwrite, pcwrite_beq, pcwrite_bne);
        end
      end
    end
  end

  logic [5:0] legal_ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b000101, 6'b001000, 6'b000010};

  initial begin
    logic [5:0] op;
    int         rst_at;
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    @(posedge clk);
    #1;
    step(0, 1'b1, 6'b000100, 1'b1);
    step(0, 1'b0, 6'b100011, 1'b1);

    run_instr(6'b100011, 0, 0, -1);  // lw: 0,1,2,3,4
    run_instr(6'b101011, 0, 2, -1);  // sw: MEMWR held 3 cycles
    run_instr(6'b000100, 0, 0, -1);  // beq
    run_instr(6'b000101, 0, 0, -1);  // bne
    run_instr(6'b111111, 0, 0, -1);  // illegal -> NOP
    run_instr(6'b100011, 0, 3, 3);   // reset during a MEMRD wait cycle
    run_instr(6'b000010, 1, 0, -1);  // j with one FETCH wait
    run_instr(6'b000000, 2, 0, -1);
    run_instr(6'b001000, 0, 0, -1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 6) == 0) op = 6'($urandom_range(0, 63));
      else                           op = legal_ops[$urandom_range(0, 6)];
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rst_at);
    end

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
